// File: rtl/ld_mem_responder.sv
// Memory-side responder for the load unit. It issues word reads to a 1-cycle RAM,
// buffers the returned data and returns it as FTk_t tokens under nack back-pressure.
package pkg_en;
    parameter int WIDTH_DATA = 16;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic [1:0]            tag;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic       n;
        logic [1:0] tag;
    } BTk_t;
endpackage

module ld_mem_responder #(
    parameter int WIDTH_ADDR = 8,
    parameter int DEPTH_RESP = 4,
    parameter int WIDTH_DATA = pkg_en::WIDTH_DATA
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Req,
    input  logic [1:0]            I_AccessMode,
    input  logic [WIDTH_ADDR-1:0] I_Address,
    output logic                  O_Stall,
    output logic                  O_Mem_Re,
    output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
    input  logic [WIDTH_DATA-1:0] I_Mem_RData,
    output pkg_en::FTk_t          O_Ld_FTk,
    input  pkg_en::BTk_t          I_Ld_BTk,
    output logic                  O_End_Load,
    output logic                  O_Busy,
    output logic                  O_Err
);

    localparam int WIDTH_FIFO = $clog2(DEPTH_RESP);
    localparam int WIDTH_CNT  = WIDTH_FIFO + 2;
    localparam logic [WIDTH_FIFO-1:0] PTR_ONE = WIDTH_FIFO'(1);
    localparam logic [WIDTH_FIFO:0]   NUM_ONE = (WIDTH_FIFO + 1)'(1);
    localparam logic [WIDTH_CNT-1:0]  CREDITS = WIDTH_CNT'(DEPTH_RESP);

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic                  a;
        logic                  r;
        logic [WIDTH_DATA-1:0] d;
    } entry_t;

    entry_t                fifo [DEPTH_RESP];
    logic [WIDTH_FIFO-1:0] wr_ptr;
    logic [WIDTH_FIFO-1:0] rd_ptr;
    logic [WIDTH_FIFO:0]   num;
    logic                  in_flight;
    logic [1:0]            pend_mode;
    logic [WIDTH_ADDR-1:0] addr_q;
    state_t                state;
    logic                  err;

    logic [WIDTH_CNT-1:0]  credit_used;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  empty;
    entry_t                head;
    logic                  unused_btk;

    // A word in flight already owns a FIFO slot, so the credit check counts it too.
    assign credit_used = {1'b0, num} + {{(WIDTH_FIFO + 1){1'b0}}, in_flight};
    assign O_Stall     = credit_used >= CREDITS;
    assign accept      = I_Req & ~O_Stall;
    assign push        = in_flight;
    assign empty       = (num == '0);
    assign head        = fifo[rd_ptr];
    assign pop         = ~empty & ~I_Ld_BTk.n;
    assign unused_btk  = ^I_Ld_BTk.tag;

    assign O_Mem_Re   = accept;
    assign O_Mem_Addr = accept ? I_Address : addr_q;
    assign O_End_Load = pop & head.r;
    assign O_Busy     = (state == BURST) | in_flight | ~empty;
    assign O_Err      = err;

    always_comb begin
        O_Ld_FTk = '0;
        if (!empty) begin
            O_Ld_FTk.v = 1'b1;
            O_Ld_FTk.a = head.a;
            O_Ld_FTk.r = head.r;
            O_Ld_FTk.d = head.d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo[wr_ptr] <= '{a: pend_mode[0], r: pend_mode[1], d: I_Mem_RData};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            num       <= '0;
            in_flight <= 1'b0;
            pend_mode <= '0;
            addr_q    <= '0;
        end else begin
            in_flight <= accept;
            if (accept) begin
                pend_mode <= I_AccessMode;
                addr_q    <= I_Address;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   num <= num + NUM_ONE;
                2'b01:   num <= num - NUM_ONE;
                default: num <= num;
            endcase
        end
    end

    // Framing violations only raise the flag; the word itself is still serviced.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            err   <= 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    case (I_AccessMode)
                        2'b01:   state <= BURST;
                        2'b11:   state <= IDLE;
                        default: err   <= 1'b1;
                    endcase
                end
                BURST: begin
                    case (I_AccessMode)
                        2'b00:   state <= BURST;
                        2'b10:   state <= IDLE;
                        default: err   <= 1'b1;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
